// File: rtl/width_conv_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : width_conv_arbiter_if
//  Description : Bundles the two byte-stream requester handshakes and the
//                byte stream driven into the shared 8->12 width converter.
//                The arbiter connects through the slave modport; the
//                requesters/converter side uses the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface width_conv_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       conv_valid;
    logic [7:0] conv_data;
    logic       conv_owner;
    logic       conv_pad;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_data,
        output req0_ready,
        input  req1_valid, req1_data,
        output req1_ready,
        output conv_valid, conv_data, conv_owner, conv_pad
    );

    // Requester / converter side
    modport master (
        output req0_valid, req0_data,
        input  req0_ready,
        output req1_valid, req1_data,
        input  req1_ready,
        input  conv_valid, conv_data, conv_owner, conv_pad
    );
endinterface
`default_nettype wire

// File: rtl/width_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : width_conv_arbiter
//  Description : Round-robin arbiter sharing one 8->12 width converter between
//                two byte-stream requesters. Ownership only changes on 3-byte
//                group boundaries so each converter group is single-sourced.
//                Optional feature macro: WIDTH_CONV_ARB_PAD_EN -- when
//                defined, a group stalled mid-way for TIMEOUT cycles is
//                completed with PAD_BYTE filler bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module width_conv_arbiter #(
    parameter int unsigned BURST_GROUPS = 4,
    parameter int unsigned TIMEOUT      = 16,
    parameter logic [7:0]  PAD_BYTE     = 8'h00
) (
    input  wire                 clk,
    input  wire                 rst_n,
    width_conv_arbiter_if.slave bus,
    output logic                busy
);

    localparam int unsigned    GW       = (BURST_GROUPS > 1) ? $clog2(BURST_GROUPS) : 1;
    localparam logic [GW-1:0]  GRP_LAST = GW'(BURST_GROUPS - 1);

    // Elaboration-time sanity checks on the configuration
    if (BURST_GROUPS < 1) begin : g_chk_burst
        $error("width_conv_arbiter: BURST_GROUPS must be >= 1");
    end
    if ((TIMEOUT < 1) || ($bits(PAD_BYTE) != 8)) begin : g_chk_timeout
        $error("width_conv_arbiter: TIMEOUT must be >= 1");
    end

`ifdef WIDTH_CONV_ARB_PAD_EN
    localparam int unsigned    SW         = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0]  STALL_LAST = SW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_PAD   = 2'd2
    } state_t;

    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic          conv_pad_q,  conv_pad_d;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1
    } state_t;
`endif

    state_t        state_q,      state_d;
    logic          owner_q,      owner_d;
    logic          last_owner_q, last_owner_d;
    logic [1:0]    byte_cnt_q,   byte_cnt_d;
    logic [GW-1:0] group_cnt_q,  group_cnt_d;
    logic          conv_valid_q, conv_valid_d;
    logic [7:0]    conv_data_q,  conv_data_d;
    logic          conv_owner_q, conv_owner_d;

    // Current owner's handshake; the non-owner's data is never looked at
    logic       owner_valid;
    logic [7:0] owner_data;
    assign owner_valid = owner_q ? bus.req1_valid : bus.req0_valid;
    assign owner_data  = owner_q ? bus.req1_data  : bus.req0_data;

    // Readies come from registered state only, never from valid
    assign bus.req0_ready = (state_q == ST_GRANT) && !owner_q;
    assign bus.req1_ready = (state_q == ST_GRANT) &&  owner_q;
    assign busy           = (state_q != ST_IDLE);

    assign bus.conv_valid = conv_valid_q;
    assign bus.conv_data  = conv_data_q;
    assign bus.conv_owner = conv_owner_q;
`ifdef WIDTH_CONV_ARB_PAD_EN
    assign bus.conv_pad   = conv_pad_q;
`else
    assign bus.conv_pad   = 1'b0;
`endif

    // Next-state, counter and converter-output decode
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        byte_cnt_d   = byte_cnt_q;
        group_cnt_d  = group_cnt_q;
        conv_valid_d = 1'b0;
        conv_data_d  = conv_data_q;
        conv_owner_d = conv_owner_q;
`ifdef WIDTH_CONV_ARB_PAD_EN
        stall_cnt_d  = stall_cnt_q;
        conv_pad_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    state_d     = ST_GRANT;
                    // Both pending: alternate away from the last owner
                    owner_d     = (bus.req0_valid && bus.req1_valid) ? !last_owner_q
                                                                     : bus.req1_valid;
                    byte_cnt_d  = 2'd0;
                    group_cnt_d = '0;
`ifdef WIDTH_CONV_ARB_PAD_EN
                    stall_cnt_d = '0;
`endif
                end
            end

            ST_GRANT: begin
                if (owner_valid) begin
                    conv_valid_d = 1'b1;
                    conv_data_d  = owner_data;
                    conv_owner_d = owner_q;
`ifdef WIDTH_CONV_ARB_PAD_EN
                    stall_cnt_d  = '0;
`endif
                    if (byte_cnt_q == 2'd2) begin
                        byte_cnt_d = 2'd0;
                        if (group_cnt_q == GRP_LAST) begin
                            state_d      = ST_IDLE;
                            last_owner_d = owner_q;
                            group_cnt_d  = '0;
                        end else begin
                            group_cnt_d  = group_cnt_q + 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else if (byte_cnt_q == 2'd0) begin
                    // Idle owner at a group boundary gives up the rest of its burst
                    if (group_cnt_q != '0) begin
                        state_d      = ST_IDLE;
                        last_owner_d = owner_q;
                    end
                end else begin
                    // Mid-group stall: the grant must hold to keep the group single-sourced
`ifdef WIDTH_CONV_ARB_PAD_EN
                    stall_cnt_d = stall_cnt_q + 1'b1;
                    if (stall_cnt_q == STALL_LAST) begin
                        state_d = ST_PAD;
                    end
`endif
                end
            end

`ifdef WIDTH_CONV_ARB_PAD_EN
            ST_PAD: begin
                conv_valid_d = 1'b1;
                conv_data_d  = PAD_BYTE;
                conv_owner_d = owner_q;
                conv_pad_d   = 1'b1;
                if (byte_cnt_q == 2'd2) begin
                    byte_cnt_d   = 2'd0;
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                end else begin
                    byte_cnt_d   = byte_cnt_q + 2'd1;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            byte_cnt_q   <= 2'd0;
            group_cnt_q  <= '0;
            conv_valid_q <= 1'b0;
            conv_data_q  <= 8'h00;
            conv_owner_q <= 1'b0;
`ifdef WIDTH_CONV_ARB_PAD_EN
            stall_cnt_q  <= '0;
            conv_pad_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            byte_cnt_q   <= byte_cnt_d;
            group_cnt_q  <= group_cnt_d;
            conv_valid_q <= conv_valid_d;
            conv_data_q  <= conv_data_d;
            conv_owner_q <= conv_owner_d;
`ifdef WIDTH_CONV_ARB_PAD_EN
            stall_cnt_q  <= stall_cnt_d;
            conv_pad_q   <= conv_pad_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_width_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_width_conv_arbiter
//  Description : Directed self-checking bench for width_conv_arbiter with a
//                scoreboard of expected converter bytes.
//                Honours WIDTH_CONV_ARB_PAD_EN for the stall/pad scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_width_conv_arbiter;

    typedef struct {
        logic       owner;
        logic       pad;
        logic [7:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    width_conv_arbiter_if bus ();

    width_conv_arbiter #(
        .BURST_GROUPS (4),
        .TIMEOUT      (4),
        .PAD_BYTE     (8'h00)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    exp_t       exp_q[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         en0 = 1'b0;
    bit         en1 = 1'b0;
    int         total = 0;
    int         bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present the head of each source queue to the DUT
    task automatic drive();
        bus.req0_valid = en0 && (q0.size() > 0);
        bus.req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
        bus.req1_valid = en1 && (q1.size() > 0);
        bus.req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
    endtask

    // Check current cycle at the falling edge, then advance to just after the next rising edge
    task automatic tick();
        bit   hs0, hs1;
        exp_t e;
        @(negedge clk);
        hs0 = bus.req0_valid && bus.req0_ready;
        hs1 = bus.req1_valid && bus.req1_ready;
        if (bus.conv_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_byte", {31'd0, bus.conv_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data",  {24'd0, bus.conv_data}, {24'd0, e.data});
                chk("sb_owner", {31'd0, bus.conv_owner}, {31'd0, e.owner});
                chk("sb_pad",   {31'd0, bus.conv_pad},   {31'd0, e.pad});
            end
        end
        @(posedge clk);
        #1;
        if (hs0) void'(q0.pop_front());
        if (hs1) void'(q1.pop_front());
        drive();
    endtask

    task automatic load(input bit which, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            if (which) q1.push_back(base + 8'(i));
            else       q0.push_back(base + 8'(i));
        end
    endtask

    task automatic expect_bytes(input bit which, input int n, input logic [7:0] base);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.owner = which;
            e.pad   = 1'b0;
            e.data  = base + 8'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic expect_pad(input bit which, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.owner = which;
            e.pad   = 1'b1;
            e.data  = 8'h00;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk(tag, exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        en0 = 1'b0;
        en1 = 1'b0;
        q0.delete();
        q1.delete();
        rst_n = 1'b0;
        drive();
        tick();
        tick();
    endtask

    initial begin
        drive();

        // Reset state
        do_reset();
        chk("rst_ready0",     {31'd0, bus.req0_ready}, 32'd0);
        chk("rst_ready1",     {31'd0, bus.req1_ready}, 32'd0);
        chk("rst_conv_valid", {31'd0, bus.conv_valid}, 32'd0);
        chk("rst_conv_owner", {31'd0, bus.conv_owner}, 32'd0);
        chk("rst_conv_pad",   {31'd0, bus.conv_pad},   32'd0);
        chk("rst_conv_data",  {24'd0, bus.conv_data},  32'd0);
        chk("rst_busy",       {31'd0, busy},           32'd0);

        // Single requester: 12 bytes, one full burst
        load(0, 12, 8'h01);
        expect_bytes(0, 12, 8'h01);
        en0   = 1'b1;
        rst_n = 1'b1;
        drive();
        tick();
        chk("single_grant_ready0", {31'd0, bus.req0_ready}, 32'd1);
        chk("single_grant_busy",   {31'd0, busy},           32'd1);
        chk("single_lat_valid",    {31'd0, bus.conv_valid}, 32'd0);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("single_stream_valid", {31'd0, bus.conv_valid}, 32'd1);
        end
        chk("single_idle_after", {31'd0, busy}, 32'd0);
        tick();
        chk("single_valid_after", {31'd0, bus.conv_valid}, 32'd0);
        chk("single_drain", exp_q.size(), 32'd0);

        // Contention: both always valid from reset, bursts alternate 0,1,0,1
        do_reset();
        load(0, 24, 8'h20);
        load(1, 24, 8'h80);
        expect_bytes(0, 12, 8'h20);
        expect_bytes(1, 12, 8'h80);
        expect_bytes(0, 12, 8'h2C);
        expect_bytes(1, 12, 8'h8C);
        en0 = 1'b1;
        en1 = 1'b1;
        drive();
        tick();
        chk("cont_rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("cont_first_owner0", {31'd0, bus.req0_ready}, 32'd1);
        chk("cont_first_not1",   {31'd0, bus.req1_ready}, 32'd0);
        for (int k = 0; k < 13; k++) tick();
        chk("cont_second_owner1", {31'd0, bus.req1_ready}, 32'd1);
        chk("cont_second_not0",   {31'd0, bus.req0_ready}, 32'd0);
        drain("cont_drain", 80);
        chk("cont_q0_consumed", q0.size(), 32'd0);
        chk("cont_q1_consumed", q1.size(), 32'd0);

        // Early release after one group
        do_reset();
        load(0, 3, 8'h40);
        load(1, 3, 8'h60);
        expect_bytes(0, 3, 8'h40);
        expect_bytes(1, 3, 8'h60);
        en0   = 1'b1;
        en1   = 1'b1;
        rst_n = 1'b1;
        drive();
        for (int k = 0; k < 3; k++) tick();
        tick();
        chk("rel_hold_busy",   {31'd0, busy},           32'd1);
        tick();
        chk("rel_idle_busy",   {31'd0, busy},           32'd0);
        chk("rel_idle_ready1", {31'd0, bus.req1_ready}, 32'd0);
        tick();
        chk("rel_grant_ready1", {31'd0, bus.req1_ready}, 32'd1);
        drain("rel_drain", 20);

        // Mid-group stall
        do_reset();
        load(0, 1, 8'hAA);
        expect_bytes(0, 1, 8'hAA);
`ifdef WIDTH_CONV_ARB_PAD_EN
        expect_pad(0, 2);
`endif
        en0   = 1'b1;
        rst_n = 1'b1;
        drive();
        tick();
        chk("stall_ready0", {31'd0, bus.req0_ready}, 32'd1);
        tick();
        for (int k = 0; k < 4; k++) tick();
        chk("stall_busy",  {31'd0, busy},           32'd1);
        chk("stall_valid", {31'd0, bus.conv_valid}, 32'd0);
`ifdef WIDTH_CONV_ARB_PAD_EN
        chk("pad_ready0", {31'd0, bus.req0_ready}, 32'd0);
        tick();
        chk("pad_flag",   {31'd0, bus.conv_pad},   32'd1);
        tick();
        chk("pad_busy_end", {31'd0, busy}, 32'd0);
        drain("pad_drain", 10);
`else
        chk("hold_ready0", {31'd0, bus.req0_ready}, 32'd1);
        for (int k = 0; k < 10; k++) tick();
        chk("hold_busy",  {31'd0, busy},           32'd1);
        chk("hold_valid", {31'd0, bus.conv_valid}, 32'd0);
        chk("hold_drain", exp_q.size(), 32'd0);
`endif

        // Reset in the middle of a req1 group
        do_reset();
        load(1, 5, 8'hC0);
        expect_bytes(1, 2, 8'hC0);
        en1   = 1'b1;
        rst_n = 1'b1;
        drive();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        en1   = 1'b0;
        drive();
        tick();
        chk("rstmid_busy",   {31'd0, busy},           32'd0);
        chk("rstmid_valid",  {31'd0, bus.conv_valid}, 32'd0);
        chk("rstmid_ready1", {31'd0, bus.req1_ready}, 32'd0);
        chk("rstmid_q1_left", q1.size(), 32'd3);
        load(0, 3, 8'hE0);
        expect_bytes(0, 3, 8'hE0);
        expect_bytes(1, 3, 8'hC2);
        en0   = 1'b1;
        en1   = 1'b1;
        rst_n = 1'b1;
        drive();
        tick();
        chk("rstmid_next_owner0", {31'd0, bus.req0_ready}, 32'd1);
        chk("rstmid_next_not1",   {31'd0, bus.req1_ready}, 32'd0);
        drain("rstmid_drain", 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
